seq_tx: RTL and testbench

- Serial bit-stream transmitter: the driving end of the detector's serial `din`/`valid` interface.
- Accepts parallel words over a ready/valid handshake and shifts each word out MSB-first, one bit per clock, as a `dout`/`dout_valid` pair.
- `dout`/`dout_valid` connect directly to the sequence detector's `din`/`valid` inputs.
- Inserts a programmable idle gap between words and keeps a count of words sent.

---
 rtl/seq_tx_pkg.sv | 16 +
 rtl/seq_tx_shifter.sv | 30 +++
 rtl/seq_tx.sv | 120 ++++++++++++
 tb/tb_seq_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and sizing helpers for the serial word transmitter.
package seq_tx_pkg;

    // Transmitter control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Width of a counter that must represent 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// WIDTH-bit parallel-load, left-shifting register exposing its MSB.
module seq_tx_shifter
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din_par,
    output logic             msb
);

    logic [WIDTH-1:0] sreg_q;

    // Load takes priority so a new word can replace the last bit of the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else if (load) begin
            sreg_q <= din_par;
        end else if (shift) begin
            sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sreg_q[WIDTH-1];

endmodule

// File: rtl/seq_tx.sv
// Serial bit-stream transmitter: accepts parallel words on a ready/valid
// handshake and sends them MSB-first as a dout/dout_valid pair, with a
// programmable idle gap between words and a wrapping sent-word counter.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int BIT_W = cnt_width(WIDTH);
    localparam int GAP_W = cnt_width(GAP + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic               load, shift, msb;
    logic               last_bit, accept;

    seq_tx_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .shift   (shift),
        .din_par (in_data),
        .msb     (msb)
    );

    // Ready is open in IDLE, and on the last bit only when words run back to back.
    assign last_bit   = (state_q == ST_SHIFT) && (bit_cnt_q == BIT_LAST);
    assign in_ready   = (state_q == ST_IDLE) || ((GAP == 0) && last_bit);
    assign accept     = in_valid && in_ready;

    // Serial outputs derive only from registered state, never from the inputs.
    assign dout_valid = (state_q == ST_SHIFT);
    assign dout       = msb && (state_q == ST_SHIFT);
    assign busy       = (state_q != ST_IDLE);
    assign words_sent = words_q;

    // State, bit/gap counters and sent-word counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            words_q   <= words_d;
        end
    end

    // Next-state, counter updates and shifter controls.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        words_d   = words_q;
        load      = 1'b0;
        shift     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                shift     = 1'b1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (last_bit) begin
                    words_d   = words_q + CNT_W'(1);
                    bit_cnt_d = '0;
                    if (GAP > 0) begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end else if (accept) begin
                        load    = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx across several GAP / CNT_W configurations.
module tb_seq_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data    [4];
    logic       in_valid   [4];
    logic       in_ready   [4];
    logic       dout       [4];
    logic       dout_valid [4];
    logic       busy       [4];
    logic [15:0] ws        [3];
    logic [1:0]  ws3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // u0: GAP=1, u1: GAP=0, u2: GAP=3, u3: GAP=1 with 2-bit counter
    seq_tx #(.WIDTH(8), .GAP(1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
        .busy(busy[0]), .words_sent(ws[0]));
    seq_tx #(.WIDTH(8), .GAP(0), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
        .busy(busy[1]), .words_sent(ws[1]));
    seq_tx #(.WIDTH(8), .GAP(3), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .dout(dout[2]), .dout_valid(dout_valid[2]),
        .busy(busy[2]), .words_sent(ws[2]));
    seq_tx #(.WIDTH(8), .GAP(1), .CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[3]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .dout(dout[3]), .dout_valid(dout_valid[3]),
        .busy(busy[3]), .words_sent(ws3));

    typedef struct {
        logic        vin;
        logic [7:0]  din;
        logic        e_dout;
        logic        e_vld;
        logic        e_rdy;
        logic        e_busy;
        logic [15:0] e_ws;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one word on instance n (which must be idle) and check its 8 serial bits.
    task automatic xmit_check(input int n, input logic [7:0] w, input string nm);
        in_valid[n] = 1'b1;
        in_data[n]  = w;
        step();
        in_valid[n] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            chk(nm, {30'd0, dout[n], dout_valid[n]}, {30'd0, w[7-b], 1'b1});
            if (b < 7) step();
        end
    endtask

    function automatic int count_1011(input bit s[$]);
        logic [3:0] win = 4'b0;
        int cnt = 0;
        for (int i = 0; i < s.size(); i++) begin
            win = {win[2:0], s[i]};
            if (i >= 3 && win == 4'b1011) cnt++;
        end
        return cnt;
    endfunction

    vec_t        tv [10];
    logic [1:0]  exp_wrap [5];
    logic [7:0]  words [20];
    bit          mdl_bits[$];
    bit          got_bits[$];
    int          blocked_err;
    int          idx;
    int          nvalid;
    bit          hs;
    int unsigned seed_dummy;
    logic [7:0]  rebuilt;

    initial begin
        for (int n = 0; n < 4; n++) begin
            in_data[n]  = 8'h00;
            in_valid[n] = 1'b0;
        end
        rst_n = 1'b0;
        #12;
        // Reset state on every instance
        for (int n = 0; n < 4; n++) begin
            chk("rst_dout", {31'd0, dout[n]}, 32'd0);
            chk("rst_vld",  {31'd0, dout_valid[n]}, 32'd0);
            chk("rst_busy", {31'd0, busy[n]}, 32'd0);
            chk("rst_rdy",  {31'd0, in_ready[n]}, 32'd1);
        end
        chk("rst_ws0", {16'd0, ws[0]}, 32'd0);
        chk("rst_ws3", {30'd0, ws3}, 32'd0);
        #10 rst_n = 1'b1;
        step();

        // ---- Single word 8'hB3, GAP=1 (table driven) ----
        tv[0] = '{1'b1, 8'hB3, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        tv[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
        tv[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        tv[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        tv[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
        tv[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
        tv[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        tv[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        tv[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
        tv[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = tv[i].vin;
            in_data[0]  = tv[i].din;
            step();
            chk("t1_dout", {31'd0, dout[0]},       {31'd0, tv[i].e_dout});
            chk("t1_vld",  {31'd0, dout_valid[0]}, {31'd0, tv[i].e_vld});
            chk("t1_rdy",  {31'd0, in_ready[0]},   {31'd0, tv[i].e_rdy});
            chk("t1_busy", {31'd0, busy[0]},       {31'd0, tv[i].e_busy});
            chk("t1_ws",   {16'd0, ws[0]},         {16'd0, tv[i].e_ws});
        end

        // ---- Back-to-back FF then 00, GAP=0 ----
        in_valid[1] = 1'b1;
        in_data[1]  = 8'hFF;
        step();
        in_data[1]  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            chk("t2_vld",  {31'd0, dout_valid[1]}, 32'd1);
            chk("t2_dout", {31'd0, dout[1]}, (i < 8) ? 32'd1 : 32'd0);
            if (i == 7) chk("t2_rdy_last", {31'd0, in_ready[1]}, 32'd1);
            if (i == 3) chk("t2_rdy_mid",  {31'd0, in_ready[1]}, 32'd0);
            step();
            if (i == 7) in_valid[1] = 1'b0;
        end
        chk("t2_vld_end", {31'd0, dout_valid[1]}, 32'd0);
        chk("t2_ws", {16'd0, ws[1]}, 32'd2);

        // ---- Backpressure, GAP=3 ----
        in_valid[2] = 1'b1;
        in_data[2]  = 8'h5A;
        step();
        in_data[2]  = 8'hC6;
        blocked_err = 0;
        for (int c = 1; c <= 11; c++) begin
            if (in_ready[2] !== 1'b0) blocked_err++;
            if (c >= 9 && dout_valid[2] !== 1'b0) blocked_err++;
            if (busy[2] !== 1'b1) blocked_err++;
            step();
        end
        chk("t3_blocked", blocked_err, 32'd0);
        chk("t3_rdy_idle", {31'd0, in_ready[2]}, 32'd1);
        chk("t3_ws", {16'd0, ws[2]}, 32'd1);
        step();
        in_valid[2] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            chk("t3_bits", {30'd0, dout[2], dout_valid[2]}, {30'd0, rebuilt_bit(8'hC6, b), 1'b1});
            step();
        end
        chk("t3_ws2", {16'd0, ws[2]}, 32'd2);

        // ---- Reset mid-word (8'hA5) ----
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hA5;
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        chk("t4_bit3", {30'd0, dout[0], dout_valid[0]}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_vld_async", {31'd0, dout_valid[0]}, 32'd0);
        chk("t4_dout_async", {31'd0, dout[0]}, 32'd0);
        chk("t4_ws_async", {16'd0, ws[0]}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("t4_rdy", {31'd0, in_ready[0]}, 32'd1);
        chk("t4_ws", {16'd0, ws[0]}, 32'd0);
        xmit_check(0, 8'h3C, "t4_bits");
        step();
        chk("t4_ws_after", {16'd0, ws[0]}, 32'd1);

        // ---- Counter wrap, CNT_W=2 ----
        exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            xmit_check(3, 8'h81 ^ 8'(i), "t5_bits");
            step();
            chk("t5_ws", {30'd0, ws3}, {30'd0, exp_wrap[i]});
            step();
            chk("t5_rdy", {31'd0, in_ready[3]}, 32'd1);
        end

        // ---- Loopback stream, 20 random words, GAP=0 ----
        seed_dummy = $urandom(25631);
        for (int j = 0; j < 20; j++) begin
            words[j] = 8'($urandom);
            for (int b = 7; b >= 0; b--) mdl_bits.push_back(words[j][b]);
        end
        idx = 0;
        nvalid = 0;
        in_valid[1] = 1'b1;
        in_data[1]  = words[0];
        for (int cyc = 0; cyc < 400 && nvalid < 160; cyc++) begin
            hs = in_ready[1] && in_valid[1];
            step();
            if (hs) begin
                idx++;
                if (idx < 20) in_data[1] = words[idx];
                else in_valid[1] = 1'b0;
            end
            if (dout_valid[1]) begin
                got_bits.push_back(dout[1]);
                nvalid++;
            end else if (nvalid > 0) begin
                nvalid = 1000;
            end
        end
        in_valid[1] = 1'b0;
        chk("t6_contiguous_bits", nvalid, 32'd160);
        for (int j = 0; j < 20; j++) begin
            rebuilt = 8'h00;
            for (int b = 0; b < 8; b++)
                if (8 * j + b < got_bits.size()) rebuilt = {rebuilt[6:0], got_bits[8*j+b]};
            chk("t6_word", {24'd0, rebuilt}, {24'd0, words[j]});
        end
        chk("t6_pattern_count", count_1011(got_bits), count_1011(mdl_bits));
        step();
        chk("t6_ws", {16'd0, ws[1]}, 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic rebuilt_bit(input logic [7:0] w, input int b);
        return w[7-b];
    endfunction

endmodule
